// File: rtl/jtag_mode_switch_ctrl_if.sv
// -----------------------------------------------------------------------------
// jtag_mode_switch_ctrl_if
//   Request/status bundle between the system/config bus and the JTAG mode
//   switch sequencer.
//
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both high. The requester holds req_valid and req_mode stable
//   until that edge. req_ready is high only while the sequencer is idle
//   (STABLE), so at most one switch is in flight.
//
//   Signals
//     req_valid     requester -> ctrl   mode-change request valid
//     req_mode      requester -> ctrl   requested mode (0=JTAG, 1=cJTAG)
//     req_ready     ctrl -> requester   sequencer idle, request can be taken
//     switch_busy   ctrl -> requester   sequence in progress
//     switch_done   ctrl -> requester   1-cycle pulse, request completed
//     switch_err    ctrl -> requester   1-cycle pulse, request rejected
//     switch_count  ctrl -> requester   completed real switches (wraps)
// -----------------------------------------------------------------------------
interface jtag_mode_switch_ctrl_if;
   logic       req_valid;
   logic       req_mode;
   logic       req_ready;
   logic       switch_busy;
   logic       switch_done;
   logic       switch_err;
   logic [7:0] switch_count;

   modport master (
      output req_valid, req_mode,
      input  req_ready, switch_busy, switch_done, switch_err, switch_count
   );

   modport slave (
      input  req_valid, req_mode,
      output req_ready, switch_busy, switch_done, switch_err, switch_count
   );
endinterface

// File: rtl/jtag_mode_switch_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_mode_switch_ctrl
//   Sequences a glitch-free switch of the dual-mode JTAG/cJTAG pin interface:
//   wait for the debug clock to go quiet, gate the pins, flip mode_select,
//   pulse the TAP reset, let things settle, then ungate.
//
//   Ports
//     clk, rst_n      system clock, asynchronous active-low reset
//     dbg_clk_mon     raw selected debug clock, asynchronous to clk
//     mode_select     registered mode to the interface mux
//     gate_en         1 = interface pins blocked
//     tap_rst_n_out   active-low TAP reset
//     state_dbg       current sequencer state (encoding of state_t)
//     bus             request/status bundle (slave side)
// -----------------------------------------------------------------------------
module jtag_mode_switch_ctrl #(
   parameter logic DEFAULT_MODE   = 1'b0,
   parameter int   IDLE_CYCLES    = 16,
   parameter int   RST_CYCLES     = 8,
   parameter int   SETTLE_CYCLES  = 4,
   parameter int   TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dbg_clk_mon,
   output logic       mode_select,
   output logic       gate_en,
   output logic       tap_rst_n_out,
   output logic [2:0] state_dbg,
   jtag_mode_switch_ctrl_if.slave bus
);

   localparam int PH_MAX_I = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW = $clog2(PH_MAX_I + 1);

   localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYCLES);
   localparam logic [TW-1:0] TOUT_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [PW-1:0] RST_MAX    = PW'(RST_CYCLES);
   localparam logic [PW-1:0] SETTLE_MAX = PW'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      ST_STABLE  = 3'd0,
      ST_QUIESCE = 3'd1,
      ST_GATE    = 3'd2,
      ST_RESET   = 3'd3,
      ST_SETTLE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   // registered outputs and internal counters
   logic          ready_q, busy_q, done_q, err_q;
   logic [7:0]    count_q;
   logic          target_q;
   logic [IW-1:0] idle_cnt;
   logic [TW-1:0] tout_cnt;
   logic [PW-1:0] phase_cnt;

   // next values from the output process
   logic          mode_nxt, gate_nxt, trst_nxt, ready_nxt, busy_nxt;
   logic          done_nxt, err_nxt, target_nxt;
   logic [7:0]    count_nxt;
   logic [IW-1:0] idle_nxt;
   logic [TW-1:0] tout_nxt;
   logic [PW-1:0] phase_nxt;

   // debug clock synchronizer; sync_q[2] only exists to detect either edge
   logic [2:0] sync_q;
   logic       dbg_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 3'b000;
      else        sync_q <= {sync_q[1:0], dbg_clk_mon};
   end

   assign dbg_edge = sync_q[1] ^ sync_q[2];

   logic          accept, same_mode, idle_hit, tout_hit, phase_rst_hit, phase_set_hit;
   logic [IW-1:0] idle_inc;
   logic [TW-1:0] tout_inc;
   logic [PW-1:0] phase_inc;

   always_comb begin
      accept        = (state == ST_STABLE) && bus.req_valid;
      same_mode     = (bus.req_mode == mode_select);
      idle_inc      = dbg_edge ? '0 : idle_cnt + 1'b1;
      tout_inc      = tout_cnt + 1'b1;
      phase_inc     = phase_cnt + 1'b1;
      idle_hit      = (idle_inc == IDLE_MAX);
      tout_hit      = (tout_inc == TOUT_MAX);
      phase_rst_hit = (phase_inc == RST_MAX);
      phase_set_hit = (phase_inc == SETTLE_MAX);
   end

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_STABLE;
      else        state <= state_nxt;
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      case (state)
         ST_STABLE:  if (accept && !same_mode) state_nxt = ST_QUIESCE;
         // idle is tested first so a clean quiet window wins over a timeout
         ST_QUIESCE: if (idle_hit)             state_nxt = ST_GATE;
                     else if (tout_hit)        state_nxt = ST_STABLE;
         ST_GATE:                              state_nxt = ST_RESET;
         ST_RESET:   if (phase_rst_hit)        state_nxt = ST_SETTLE;
         ST_SETTLE:  if (phase_set_hit)        state_nxt = ST_STABLE;
         default:                              state_nxt = ST_STABLE;
      endcase
   end

   // ---- output logic: next values of every registered output ----
   always_comb begin
      mode_nxt   = mode_select;
      gate_nxt   = gate_en;
      trst_nxt   = tap_rst_n_out;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      count_nxt  = count_q;
      target_nxt = target_q;
      idle_nxt   = idle_cnt;
      tout_nxt   = tout_cnt;
      phase_nxt  = phase_cnt;
      case (state)
         ST_STABLE: begin
            if (accept) begin
               if (same_mode) begin
                  done_nxt = 1'b1;
               end else begin
                  target_nxt = bus.req_mode;
                  idle_nxt   = '0;
                  tout_nxt   = '0;
               end
            end
         end
         ST_QUIESCE: begin
            idle_nxt = idle_inc;
            tout_nxt = tout_inc;
            if (idle_hit)      gate_nxt = 1'b1;
            else if (tout_hit) err_nxt  = 1'b1;
         end
         ST_GATE: begin
            // pins are already blocked here, so the mux can switch safely
            mode_nxt  = target_q;
            trst_nxt  = 1'b0;
            phase_nxt = '0;
         end
         ST_RESET: begin
            phase_nxt = phase_inc;
            if (phase_rst_hit) begin
               trst_nxt  = 1'b1;
               phase_nxt = '0;
            end
         end
         ST_SETTLE: begin
            phase_nxt = phase_inc;
            if (phase_set_hit) begin
               gate_nxt  = 1'b0;
               done_nxt  = 1'b1;
               count_nxt = count_q + 8'd1;
               phase_nxt = '0;
            end
         end
         default: begin
            gate_nxt = 1'b0;
            trst_nxt = 1'b1;
         end
      endcase
      ready_nxt = (state_nxt == ST_STABLE);
      busy_nxt  = (state_nxt != ST_STABLE);
   end

   // ---- output / counter registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_select   <= DEFAULT_MODE;
         gate_en       <= 1'b0;
         tap_rst_n_out <= 1'b1;
         ready_q       <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         count_q       <= 8'd0;
         target_q      <= DEFAULT_MODE;
         idle_cnt      <= '0;
         tout_cnt      <= '0;
         phase_cnt     <= '0;
      end else begin
         mode_select   <= mode_nxt;
         gate_en       <= gate_nxt;
         tap_rst_n_out <= trst_nxt;
         ready_q       <= ready_nxt;
         busy_q        <= busy_nxt;
         done_q        <= done_nxt;
         err_q         <= err_nxt;
         count_q       <= count_nxt;
         target_q      <= target_nxt;
         idle_cnt      <= idle_nxt;
         tout_cnt      <= tout_nxt;
         phase_cnt     <= phase_nxt;
      end
   end

   assign bus.req_ready    = ready_q;
   assign bus.switch_busy  = busy_q;
   assign bus.switch_done  = done_q;
   assign bus.switch_err   = err_q;
   assign bus.switch_count = count_q;
   assign state_dbg        = state;

endmodule

// File: tb/tb_jtag_mode_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jtag_mode_switch_ctrl
//   Drives mode-change requests and debug-clock activity into
//   jtag_mode_switch_ctrl. Each request pushes its expected completion
//   (err/done, resulting mode, count, latency) into exp_q; the monitor pops
//   and compares on every done/err pulse. Latency counts the accept cycle as
//   cycle 1 and is measured at the first sample where the pulse is visible.
// -----------------------------------------------------------------------------
module tb_jtag_mode_switch_ctrl;

   localparam int IDLE_CYCLES    = 16;
   localparam int RST_CYCLES     = 8;
   localparam int SETTLE_CYCLES  = 4;
   localparam int TIMEOUT_CYCLES = 1024;

   localparam int LAT_SAME   = 1;
   localparam int LAT_SWITCH = IDLE_CYCLES + RST_CYCLES + SETTLE_CYCLES + 2;  // 30
   localparam int LAT_TOUT   = TIMEOUT_CYCLES + 1;
   localparam int GATE_LEN   = 1 + RST_CYCLES + SETTLE_CYCLES;               // 13

   // ---- clock / reset ----
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       dbg_clk_mon = 1'b0;
   logic       mode_select, gate_en, tap_rst_n_out;
   logic [2:0] state_dbg;

   jtag_mode_switch_ctrl_if bus ();

   jtag_mode_switch_ctrl #(
      .DEFAULT_MODE   (1'b0),
      .IDLE_CYCLES    (IDLE_CYCLES),
      .RST_CYCLES     (RST_CYCLES),
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dbg_clk_mon   (dbg_clk_mon),
      .mode_select   (mode_select),
      .gate_en       (gate_en),
      .tap_rst_n_out (tap_rst_n_out),
      .state_dbg     (state_dbg),
      .bus           (bus.slave)
   );

   // ---- check / bookkeeping ----
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // {err, done, mode, count[7:0], latency[11:0]}
   localparam int W = 23;
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] mk_exp(input logic err, input logic done,
                                           input logic mode, input logic [7:0] cnt,
                                           input int lat);
      logic [11:0] l;
      l = 12'(lat);
      return {err, done, mode, cnt, l};
   endfunction

   int   cyc = 0;
   int   acc_cyc = 0;
   int   gate_rise_cyc = 0;
   int   last_t = 0;
   logic skip_runs = 1'b1;
   logic model_mode = 1'b0;
   logic [7:0] model_count = 8'd0;

   // cycle counter and accept-edge capture
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (rst_n && bus.req_valid && bus.req_ready) acc_cyc = cyc;
      end
   end

   // ---- monitor / scoreboard ----
   initial begin
      logic [W-1:0] e;
      int gate_run, trst_run;
      logic prev_mode, prev_gate;
      gate_run  = 0;
      trst_run  = 0;
      prev_mode = 1'b0;
      prev_gate = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.switch_done || bus.switch_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("err",     int'(bus.switch_err),   int'(e[22]));
               check("done",    int'(bus.switch_done),  int'(e[21]));
               check("mode",    int'(mode_select),      int'(e[20]));
               check("count",   int'(bus.switch_count), int'(e[19:12]));
               check("latency", cyc - acc_cyc + 1,      int'(e[11:0]));
            end
         end
         if (skip_runs) begin
            gate_run = 0;
            trst_run = 0;
         end else begin
            if (gate_en && !prev_gate) gate_rise_cyc = cyc;
            if (gate_en) gate_run++;
            else if (gate_run != 0) begin
               check("gate_len", gate_run, GATE_LEN);
               gate_run = 0;
            end
            if (!tap_rst_n_out) trst_run++;
            else if (trst_run != 0) begin
               check("trst_len", trst_run, RST_CYCLES);
               trst_run = 0;
            end
            if (mode_select != prev_mode) begin
               check("mode_gated",   int'(gate_en), 1);
               check("mode_flip_at", cyc - gate_rise_cyc, 1);
            end
         end
         prev_mode = mode_select;
         prev_gate = gate_en;
      end
   end

   // ---- driver tasks ----
   task automatic send_req(input logic mode, input int hold);
      int k;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_mode  = mode;
      k = 0;
      do begin
         @(posedge clk);
         k++;
      end while (!bus.req_ready && k < 5000);
      if (k >= 5000) check("accept_timeout", 0, 1);
      repeat (hold) @(negedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_mode  = $urandom_range(0, 1);
   endtask

   task automatic wait_drain(input int budget);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic toggle_dbg(input int n_toggles);
      for (int k = 0; k < n_toggles; k++) begin
         repeat (10) @(negedge clk);
         dbg_clk_mon = ~dbg_clk_mon;
         last_t = cyc + 1;
      end
   endtask

   task automatic push_switch(input logic mode);
      model_mode  = mode;
      model_count = model_count + 8'd1;
      exp_q.push_back(mk_exp(1'b0, 1'b1, model_mode, model_count, LAT_SWITCH));
   endtask

   // ---- main sequence ----
   initial begin
      bus.req_valid = 1'b0;
      bus.req_mode  = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_ready", int'(bus.req_ready),    1);
      check("rst_busy",  int'(bus.switch_busy),  0);
      check("rst_done",  int'(bus.switch_done),  0);
      check("rst_err",   int'(bus.switch_err),   0);
      check("rst_count", int'(bus.switch_count), 0);
      check("rst_mode",  int'(mode_select),      0);
      check("rst_gate",  int'(gate_en),          0);
      check("rst_trst",  int'(tap_rst_n_out),    1);
      check("rst_state", int'(state_dbg),        0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      skip_runs = 1'b0;

      // quiet clock, JTAG -> cJTAG
      push_switch(1'b1);
      send_req(1'b1, 0);
      @(negedge clk);
      check("busy_in_seq",  int'(bus.switch_busy), 1);
      check("ready_in_seq", int'(bus.req_ready),   0);
      wait_drain(200);

      // same-mode request: immediate done, no gating, count unchanged
      exp_q.push_back(mk_exp(1'b0, 1'b1, model_mode, model_count, LAT_SAME));
      send_req(1'b1, 0);
      wait_drain(50);

      // busy debug clock for 2000 cycles: timeout, mode unchanged
      exp_q.push_back(mk_exp(1'b1, 1'b0, model_mode, model_count, LAT_TOUT));
      fork
         toggle_dbg(200);
         send_req(1'b0, 0);
      join
      wait_drain(200);
      check("tout_mode", int'(mode_select), int'(model_mode));

      // debug clock stops after 500 cycles of QUIESCE, then a normal switch
      send_req(1'b0, 0);
      toggle_dbg(50);
      model_mode  = 1'b0;
      model_count = model_count + 8'd1;
      exp_q.push_back(mk_exp(1'b0, 1'b1, model_mode, model_count,
                             last_t + 2 + IDLE_CYCLES + GATE_LEN - acc_cyc + 1));
      wait_drain(300);

      // reset asserted while the TAP reset is low
      send_req(1'b1, 0);
      for (int k = 0; k < 100 && tap_rst_n_out; k++) @(negedge clk);
      check("trst_reached", int'(tap_rst_n_out), 0);
      repeat (3) @(negedge clk);
      skip_runs = 1'b1;
      rst_n = 1'b0;
      #1;
      check("abort_mode",  int'(mode_select),      0);
      check("abort_gate",  int'(gate_en),          0);
      check("abort_trst",  int'(tap_rst_n_out),    1);
      check("abort_ready", int'(bus.req_ready),    1);
      check("abort_busy",  int'(bus.switch_busy),  0);
      check("abort_count", int'(bus.switch_count), 0);
      check("abort_state", int'(state_dbg),        0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_mode  = 1'b0;
      model_count = 8'd0;
      repeat (2) @(negedge clk);
      skip_runs = 1'b0;

      // 256 alternating switches; first request held valid while busy
      for (int i = 0; i < 256; i++) begin
         push_switch(~model_mode);
         send_req(model_mode, (i == 0) ? 20 : 0);
         wait_drain(200);
      end
      check("wrap_count", int'(bus.switch_count), 0);
      check("wrap_mode",  int'(mode_select),      0);
      check("final_idle", int'(bus.req_ready),    1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      check("global_timeout", 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "watchdog expired");
   end

endmodule
